// File: rtl/tdc_pkg.sv
// Shared widths, state encoding and beat payload for the TDC output stage.
package tdc_pkg;

  localparam int unsigned TOF_W  = 10;
  localparam int unsigned INT_W  = 5;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned NUM_W  = 2;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned DROP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [TOF_W-1:0] tof;
    logic [INT_W-1:0] inten;
  } beat_t;

  // Extract one slot's (tof, intensity) pair from the flattened frame buses.
  function automatic beat_t slot_beat(input logic [DEPTH*TOF_W-1:0] tof_bus,
                                      input logic [DEPTH*INT_W-1:0] int_bus,
                                      input logic [IDX_W-1:0]       idx);
    beat_t b;
    b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == IDX_W'(i)) begin
        b.tof   = tof_bus[i*TOF_W +: TOF_W];
        b.inten = int_bus[i*INT_W +: INT_W];
      end
    end
    return b;
  endfunction

  // Slot index stored at a given position of the sorted order word.
  function automatic logic [IDX_W-1:0] order_at(input logic [DEPTH*IDX_W-1:0] order,
                                                input logic [IDX_W-1:0]       pos);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pos == IDX_W'(i)) r = order[i*IDX_W +: IDX_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_out_stream_if.sv
// Readout stream towards the TDC_O* pins: one result per beat, ready/valid.
interface tdc_out_stream_if;
  import tdc_pkg::*;

  logic [TOF_W-1:0] TDC_Odata;
  logic [INT_W-1:0] TDC_Oint;
  logic [NUM_W-1:0] TDC_Onum;
  logic             TDC_Ovalid;
  logic             TDC_Oready;
  logic             TDC_Olast;

  modport master (
    output TDC_Odata, TDC_Oint, TDC_Onum, TDC_Ovalid, TDC_Olast,
    input  TDC_Oready
  );

  modport slave (
    input  TDC_Odata, TDC_Oint, TDC_Onum, TDC_Ovalid, TDC_Olast,
    output TDC_Oready
  );

endinterface

// File: rtl/tdc_sort3.sv
// Combinational 3-slot sorter: slot order by descending intensity, ties to the
// lower slot index, so the resulting order is always a permutation.
module tdc_sort3
  import tdc_pkg::*;
(
  input  logic [DEPTH*INT_W-1:0] int_i,
  output logic [DEPTH*IDX_W-1:0] order_o
);

  logic [INT_W-1:0] val  [DEPTH];
  logic [IDX_W-1:0] rank [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      val[i] = int_i[i*INT_W +: INT_W];
    end

    // Rank = number of slots that must precede this one.
    for (int i = 0; i < DEPTH; i++) begin
      rank[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i) begin
          if ((val[j] > val[i]) || ((val[j] == val[i]) && (j < i))) begin
            rank[i] = rank[i] + IDX_W'(1);
          end
        end
      end
    end

    order_o = '0;
    for (int p = 0; p < DEPTH; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rank[i] == IDX_W'(p)) order_o[p*IDX_W +: IDX_W] = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tdc_out_stream.sv
// TDC output stage: snapshots frame results, sorts them by intensity and
// streams them one beat at a time on the readout interface.
module tdc_out_stream
  import tdc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_done,
  input  logic [NUM_W-1:0]       frame_num,
  input  logic [DEPTH*TOF_W-1:0] frame_tof,
  input  logic [DEPTH*INT_W-1:0] frame_int,
  tdc_out_stream_if.master       o_if,
  output logic                   busy,
  output logic [DROP_W-1:0]      drop_cnt
);

  state_e                 state_q,    state_d;
  logic [DEPTH*TOF_W-1:0] snap_tof_q, snap_tof_d;
  logic [DEPTH*INT_W-1:0] snap_int_q, snap_int_d;
  logic [NUM_W-1:0]       snap_num_q, snap_num_d;
  logic [DEPTH*IDX_W-1:0] order_q,    order_d;
  logic [IDX_W-1:0]       beat_q,     beat_d;
  beat_t                  beat_out_q, beat_out_d;
  logic [NUM_W-1:0]       num_out_q,  num_out_d;
  logic                   valid_q,    valid_d;
  logic                   last_q,     last_d;
  logic                   busy_q,     busy_d;
  logic [DROP_W-1:0]      drop_q,     drop_d;

  logic [DEPTH*IDX_W-1:0] sort_order;
  logic                   xfer;
  logic                   last_xfer;
  logic                   capture;
  logic                   drop;
  logic [IDX_W-1:0]       load_pos;

  tdc_sort3 u_sort (
    .int_i   (snap_int_q),
    .order_o (sort_order)
  );

  // Next-state, snapshot, beat and drop-counter logic.
  always_comb begin
    state_d    = state_q;
    snap_tof_d = snap_tof_q;
    snap_int_d = snap_int_q;
    snap_num_d = snap_num_q;
    order_d    = order_q;
    beat_d     = beat_q;
    beat_out_d = beat_out_q;
    num_out_d  = num_out_q;
    valid_d    = valid_q;
    last_d     = last_q;
    drop_d     = drop_q;

    xfer      = valid_q && o_if.TDC_Oready;
    last_xfer = (state_q == ST_SEND) && xfer && last_q;
    capture   = frame_done && (frame_num != '0) && ((state_q == ST_IDLE) || last_xfer);
    drop      = frame_done && ((state_q == ST_SORT) || ((state_q == ST_SEND) && !last_xfer));
    // First SEND cycle loads beat 0; afterwards each transfer loads the next.
    load_pos  = valid_q ? (beat_q + IDX_W'(1)) : beat_q;

    case (state_q)
      ST_IDLE: ;
      ST_SORT: begin
        order_d = sort_order;
        beat_d  = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (last_xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!valid_q || xfer) begin
          beat_d     = load_pos;
          beat_out_d = slot_beat(snap_tof_q, snap_int_q, order_at(order_q, load_pos));
          num_out_d  = snap_num_q;
          valid_d    = 1'b1;
          last_d     = ((NUM_W'(load_pos) + NUM_W'(1)) == snap_num_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      snap_tof_d = frame_tof;
      snap_int_d = frame_int;
      snap_num_d = frame_num;
      state_d    = ST_SORT;
    end

    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      snap_tof_q <= '0;
      snap_int_q <= '0;
      snap_num_q <= '0;
      order_q    <= '0;
      beat_q     <= '0;
      beat_out_q <= '0;
      num_out_q  <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      snap_tof_q <= snap_tof_d;
      snap_int_q <= snap_int_d;
      snap_num_q <= snap_num_d;
      order_q    <= order_d;
      beat_q     <= beat_d;
      beat_out_q <= beat_out_d;
      num_out_q  <= num_out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign o_if.TDC_Odata  = beat_out_q.tof;
  assign o_if.TDC_Oint   = beat_out_q.inten;
  assign o_if.TDC_Onum   = num_out_q;
  assign o_if.TDC_Ovalid = valid_q;
  assign o_if.TDC_Olast  = last_q;
  assign busy            = busy_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_tdc_out_stream.sv
// Self-checking bench for tdc_out_stream: directed vectors, corner sequences
// and random traffic against a frame-level reference model.
module tb_tdc_out_stream;
  import tdc_pkg::*;

  typedef struct { int tof; int inten; int num; int last; } obs_t;
  typedef struct { int tof; int inten; int num; } exp_t;
  typedef struct {
    int num;
    int t0, t1, t2;
    int i0, i1, i2;
    int et0, ei0, et1, ei1, et2, ei2;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   frame_done = 1'b0;
  logic [NUM_W-1:0]       frame_num = '0;
  logic [DEPTH*TOF_W-1:0] frame_tof = '0;
  logic [DEPTH*INT_W-1:0] frame_int = '0;
  logic                   busy;
  logic [DROP_W-1:0]      drop_cnt;

  tdc_out_stream_if o_if ();

  tdc_out_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_done (frame_done),
    .frame_num  (frame_num),
    .frame_tof  (frame_tof),
    .frame_int  (frame_int),
    .o_if       (o_if),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #2 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  obs_t got_q[$];
  exp_t exp_q[$];
  int   m_left = 0, m_wait = 0, m_drops = 0, m_beats = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_frame(input int num, input int t0, input int t1, input int t2,
                             input int i0, input int i1, input int i2);
    frame_num  = NUM_W'(num);
    frame_tof  = {TOF_W'(t2), TOF_W'(t1), TOF_W'(t0)};
    frame_int  = {INT_W'(i2), INT_W'(i1), INT_W'(i0)};
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Reference: a frame is the first num slots ordered by intensity (stable).
  function automatic void model_accept();
    int t[3];
    int v[3];
    bit used[3];
    int best;
    for (int i = 0; i < 3; i++) begin
      t[i]    = int'(frame_tof[i*TOF_W +: TOF_W]);
      v[i]    = int'(frame_int[i*INT_W +: INT_W]);
      used[i] = 1'b0;
    end
    for (int p = 0; p < int'(frame_num); p++) begin
      best = -1;
      for (int i = 0; i < 3; i++)
        if (!used[i] && (best < 0 || v[i] > v[best])) best = i;
      used[best] = 1'b1;
      exp_q.push_back('{t[best], v[best], int'(frame_num)});
    end
    m_left  = int'(frame_num);
    m_wait  = 2;
    m_beats += int'(frame_num);
  endfunction

  // Timeline model: accepted at edge N, beats offered from edge N+2.
  initial begin : model
    bit busy_b, offered, lastx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0; m_wait = 0; m_drops = 0;
        exp_q.delete();
      end else begin
        busy_b  = (m_left > 0);
        offered = busy_b && (m_wait == 0);
        lastx   = offered && o_if.TDC_Oready && (m_left == 1);
        if (offered && o_if.TDC_Oready) begin
          m_left--;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (busy_b && m_wait > 0) begin
          m_wait--;
        end
        if (frame_done) begin
          if (!busy_b || lastx) begin
            if (frame_num != '0) model_accept();
          end else if (m_drops < 255) begin
            m_drops++;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, stall stability, transfer capture.
  initial begin : monitor
    bit ev, stall_prev;
    int p_data, p_int, p_num, p_last;
    stall_prev = 1'b0;
    p_data = 0; p_int = 0; p_num = 0; p_last = 0;
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        ev = (m_left > 0) && (m_wait == 0);
        chk("valid", int'(o_if.TDC_Ovalid), int'(ev));
        chk("busy", int'(busy), int'(m_left > 0));
        chk("drop_cnt", int'(drop_cnt), m_drops);
        if (ev && exp_q.size() > 0) begin
          chk("data", int'(o_if.TDC_Odata), exp_q[0].tof);
          chk("int", int'(o_if.TDC_Oint), exp_q[0].inten);
          chk("last", int'(o_if.TDC_Olast), int'(m_left == 1));
          chk("num", int'(o_if.TDC_Onum), exp_q[0].num);
        end
        if (stall_prev) begin
          chk("stall_valid", int'(o_if.TDC_Ovalid), 1);
          chk("stall_data", int'(o_if.TDC_Odata), p_data);
          chk("stall_int", int'(o_if.TDC_Oint), p_int);
          chk("stall_num", int'(o_if.TDC_Onum), p_num);
          chk("stall_last", int'(o_if.TDC_Olast), p_last);
        end
      end
      if (rst_n && o_if.TDC_Ovalid && o_if.TDC_Oready)
        got_q.push_back('{int'(o_if.TDC_Odata), int'(o_if.TDC_Oint),
                          int'(o_if.TDC_Onum), int'(o_if.TDC_Olast)});
      stall_prev = rst_n && o_if.TDC_Ovalid && !o_if.TDC_Oready;
      p_data = int'(o_if.TDC_Odata);
      p_int  = int'(o_if.TDC_Oint);
      p_num  = int'(o_if.TDC_Onum);
      p_last = int'(o_if.TDC_Olast);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_beats(input string tag, input vec_t v);
    int et[3];
    int ei[3];
    et = '{v.et0, v.et1, v.et2};
    ei = '{v.ei0, v.ei1, v.ei2};
    chk({tag, "_count"}, got_q.size(), v.num);
    for (int b = 0; b < v.num; b++) begin
      if (b < got_q.size()) begin
        chk({tag, "_tof"}, got_q[b].tof, et[b]);
        chk({tag, "_int"}, got_q[b].inten, ei[b]);
        chk({tag, "_last"}, got_q[b].last, int'(b == v.num - 1));
        chk({tag, "_num"}, got_q[b].num, v.num);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin : stim
    vec_t vecs[6];
    int   base;

    vecs[0] = '{3, 100, 200, 300, 3, 9, 5,   200, 9, 300, 5, 100, 3};
    vecs[1] = '{2, 11, 22, 33,    7, 7, 2,   11, 7, 22, 7, -1, -1};
    vecs[2] = '{1, 5, 6, 7,       1, 2, 3,   7, 3, -1, -1, -1, -1};
    vecs[3] = '{3, 1023, 0, 512,  31, 0, 31, 1023, 31, 512, 31, 0, 0};
    vecs[4] = '{3, 1, 2, 3,       4, 4, 4,   1, 4, 2, 4, 3, 4};
    vecs[5] = '{2, 9, 8, 7,       0, 8, 8,   8, 8, 7, 8, -1, -1};

    o_if.TDC_Oready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(o_if.TDC_Ovalid), 0);
    chk("rst_last", int'(o_if.TDC_Olast), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_data", int'(o_if.TDC_Odata), 0);
    chk("rst_int", int'(o_if.TDC_Oint), 0);
    chk("rst_num", int'(o_if.TDC_Onum), 0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Directed vectors with ready held high, including first-beat latency.
    for (int k = 0; k < 6; k++) begin
      got_q.delete();
      apply_frame(vecs[k].num, vecs[k].t0, vecs[k].t1, vecs[k].t2,
                  vecs[k].i0, vecs[k].i1, vecs[k].i2);
      chk("lat_n0", int'(o_if.TDC_Ovalid), 0);
      chk("lat_busy", int'(busy), 1);
      tick();
      chk("lat_n1", int'(o_if.TDC_Ovalid), 0);
      tick();
      chk("lat_n2", int'(o_if.TDC_Ovalid), 1);
      wait_idle(20);
      check_beats("vec", vecs[k]);
    end

    // Backpressure: 5 stalled cycles, then ready 1,0,1,0,1.
    got_q.delete();
    o_if.TDC_Oready = 1'b0;
    apply_frame(3, 100, 200, 300, 3, 9, 5);
    repeat (2) tick();
    repeat (5) tick();
    chk("bp_hold_count", got_q.size(), 0);
    for (int r = 0; r < 5; r++) begin
      o_if.TDC_Oready = ((r % 2) == 0);
      tick();
    end
    chk("bp_done_valid", int'(o_if.TDC_Ovalid), 0);
    o_if.TDC_Oready = 1'b1;
    wait_idle(20);
    check_beats("bp", vecs[0]);

    // Drop mid-SEND: first frame completes intact.
    do_reset();
    got_q.delete();
    o_if.TDC_Oready = 1'b0;
    apply_frame(3, 100, 200, 300, 3, 9, 5);
    repeat (3) tick();
    apply_frame(2, 11, 22, 33, 7, 7, 2);
    chk("drop_mid", int'(drop_cnt), 1);
    o_if.TDC_Oready = 1'b1;
    wait_idle(20);
    check_beats("drop_keep", vecs[0]);

    // Frame_done coincident with the last-beat transfer is accepted.
    got_q.delete();
    apply_frame(2, 11, 22, 33, 7, 7, 2);
    repeat (3) tick();
    apply_frame(3, 100, 200, 300, 3, 9, 5);
    chk("coin_drop", int'(drop_cnt), 1);
    chk("coin_busy", int'(busy), 1);
    chk("coin_v0", int'(o_if.TDC_Ovalid), 0);
    tick();
    chk("coin_v1", int'(o_if.TDC_Ovalid), 0);
    tick();
    chk("coin_v2", int'(o_if.TDC_Ovalid), 1);
    chk("coin_first", int'(o_if.TDC_Odata), 200);
    wait_idle(20);
    chk("coin_count", got_q.size(), 5);

    // Empty frame is ignored.
    apply_frame(0, 1, 2, 3, 4, 5, 6);
    for (int c = 0; c < 4; c++) begin
      chk("empty_valid", int'(o_if.TDC_Ovalid), 0);
      chk("empty_busy", int'(busy), 0);
      chk("empty_drop", int'(drop_cnt), 1);
      tick();
    end

    // Drop counter saturation.
    o_if.TDC_Oready = 1'b0;
    apply_frame(1, 5, 6, 7, 1, 2, 3);
    frame_done = 1'b1;
    repeat (300) tick();
    frame_done = 1'b0;
    chk("drop_sat", int'(drop_cnt), 255);
    o_if.TDC_Oready = 1'b1;
    wait_idle(20);

    // Reset during beat 2 of 3, then a clean frame.
    got_q.delete();
    apply_frame(3, 100, 200, 300, 3, 9, 5);
    repeat (3) tick();
    chk("pre_rst_data", int'(o_if.TDC_Odata), 300);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_if.TDC_Ovalid), 0);
    chk("arst_last", int'(o_if.TDC_Olast), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_drop", int'(drop_cnt), 0);
    chk("arst_data", int'(o_if.TDC_Odata), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    got_q.delete();
    apply_frame(2, 11, 22, 33, 7, 7, 2);
    wait_idle(20);
    check_beats("post_rst", vecs[1]);

    // Random traffic against the reference model.
    got_q.delete();
    base = m_beats;
    for (int f = 0; f < 150; f++) begin
      int gap;
      gap = int'($urandom_range(0, 6));
      for (int g = 0; g < gap; g++) begin
        o_if.TDC_Oready = ($urandom_range(0, 9) < 7);
        tick();
      end
      o_if.TDC_Oready = ($urandom_range(0, 9) < 7);
      apply_frame(int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)));
    end
    o_if.TDC_Oready = 1'b1;
    wait_idle(50);
    tick();
    chk("rand_beats", got_q.size(), m_beats - base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
